// File: rtl/dp_sched_pkg.sv
// rtl/dp_sched_pkg.sv - shared constants and FSM state type for the dot-product row scheduler
package dp_sched_pkg;

    localparam int PKG_GAP    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ROW_START,
        ISSUE,
        WAIT_PREP,
        DRAIN
    } state_t;

endpackage

// File: rtl/dp_result_fifo.sv
// rtl/dp_result_fifo.sv - FIFO_DEPTH-entry result buffer holding {row index, row result}
module dp_result_fifo
    import dp_sched_pkg::*;
#(
    parameter int DATA_W = 40
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     pop_data,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [FIFO_CNT_W-1:0] FULL_CNT = FIFO_CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full buffer is still taken when the same cycle pops.
    assign do_push  = push && ((count != FULL_CNT) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/dp_row_scheduler.sv
// rtl/dp_row_scheduler.sv - row/package scheduler for a dot-product unit; DP_SCHED_PERF_EN adds perf_stall
module dp_row_scheduler
    import dp_sched_pkg::*;
#(
    parameter int ELEM_W  = 32,
    parameter int MULT_W  = 3,
    parameter int ADDR_W  = 10,
    parameter int ROW_W   = 8,
    parameter int PKG_GAP = dp_sched_pkg::PKG_GAP
)(
    input  logic              clk,
    input  logic              reset,
`ifdef DP_SCHED_PERF_EN
    output logic [15:0]       perf_stall,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ROW_W-1:0]  cmd_rows,
    input  logic [MULT_W-1:0] cmd_pkgs,
    input  logic [ADDR_W-1:0] cmd_base,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              dp_row_start,
    output logic [MULT_W-1:0] dp_no_of_multiples,
    output logic              dp_read_now,
    input  logic              dp_prepare,
    input  logic              dp_finish,
    input  logic [ELEM_W-1:0] dp_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ELEM_W-1:0] res_data,
    output logic [ROW_W-1:0]  res_row,
    output logic              busy,
    output logic              done
);
    localparam int GAP_W = (PKG_GAP > 1) ? $clog2(PKG_GAP) : 1;

    state_t                  state, next;
    logic [ROW_W-1:0]        rows_r, row_idx, fin_row;
    logic [MULT_W-1:0]       pkgs_r, pkg_k;
    logic [ADDR_W-1:0]       addr_r;
    logic [GAP_W-1:0]        gap_cnt;
    logic [2:0]              outstanding;
    logic                    finish_d;
    logic                    fin_rise;
    logic                    accept;
    logic                    last_pkg, last_row;
    logic                    buf_full;
    logic [3:0]              cnt_sum;
    logic                    fifo_empty;
    logic [FIFO_CNT_W-1:0]   fifo_count;
    logic [ROW_W+ELEM_W-1:0] fifo_dout;

    assign accept   = cmd_ready && cmd_valid;
    assign last_pkg = (pkg_k == pkgs_r - 1'b1);
    assign last_row = (row_idx == rows_r - 1'b1);
    // Rows in flight plus results waiting must never exceed the buffer depth.
    assign cnt_sum  = {1'b0, outstanding} + 4'(fifo_count);
    assign buf_full = (cnt_sum >= 4'(FIFO_DEPTH));
    assign fin_rise = dp_finish && !finish_d && (outstanding != 3'd0);

    always_comb begin
        next         = state;
        cmd_ready    = 1'b0;
        dp_row_start = 1'b0;
        mem_rd_en    = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    next = (cmd_rows == '0 || cmd_pkgs == '0) ? DRAIN : ROW_START;
                end
            end
            ROW_START: begin
                if (!buf_full) begin
                    dp_row_start = 1'b1;
                    next         = ISSUE;
                end
            end
            ISSUE: begin
                if (gap_cnt == '0) begin
                    mem_rd_en = 1'b1;
                    if (last_pkg) begin
                        next = last_row ? DRAIN : WAIT_PREP;
                    end
                end
            end
            WAIT_PREP: begin
                if (dp_prepare) begin
                    next = ROW_START;
                end
            end
            DRAIN: begin
                if (fifo_empty && outstanding == 3'd0) begin
                    done = 1'b1;
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rows_r      <= '0;
            pkgs_r      <= '0;
            addr_r      <= '0;
            row_idx     <= '0;
            fin_row     <= '0;
            pkg_k       <= '0;
            gap_cnt     <= '0;
            outstanding <= '0;
            finish_d    <= 1'b0;
            dp_read_now <= 1'b0;
        end else begin
            state       <= next;
            finish_d    <= dp_finish;
            dp_read_now <= mem_rd_en;
            if (accept) begin
                rows_r  <= cmd_rows;
                pkgs_r  <= cmd_pkgs;
                addr_r  <= cmd_base;
                row_idx <= '0;
                fin_row <= '0;
            end
            if (dp_row_start) begin
                pkg_k   <= '0;
                gap_cnt <= '0;
            end else if (mem_rd_en) begin
                addr_r  <= addr_r + 1'b1;
                pkg_k   <= pkg_k + 1'b1;
                gap_cnt <= GAP_W'(PKG_GAP - 1);
                if (last_pkg) begin
                    row_idx <= row_idx + 1'b1;
                end
            end else if (state == ISSUE && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (dp_row_start && !fin_rise) begin
                outstanding <= outstanding + 1'b1;
            end else if (!dp_row_start && fin_rise) begin
                outstanding <= outstanding - 1'b1;
            end
            if (fin_rise) begin
                fin_row <= fin_row + 1'b1;
            end
        end
    end

    dp_result_fifo #(
        .DATA_W(ROW_W + ELEM_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fin_rise),
        .push_data({fin_row, dp_result}),
        .pop      (res_valid && res_ready),
        .pop_data (fifo_dout),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign res_valid          = !fifo_empty;
    assign res_data           = fifo_empty ? '0 : fifo_dout[ELEM_W-1:0];
    assign res_row            = fifo_empty ? '0 : fifo_dout[ROW_W+ELEM_W-1:ELEM_W];
    assign mem_rd_addr        = addr_r;
    assign dp_no_of_multiples = pkgs_r;
    assign busy               = (state != IDLE);

`ifdef DP_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            perf_stall <= '0;
        end else if (((state == WAIT_PREP && !dp_prepare) || (state == ROW_START && buf_full))
                     && perf_stall != 16'hFFFF) begin
            perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dp_row_scheduler.sv
// tb/tb_dp_row_scheduler.sv - scoreboard bench for dp_row_scheduler with a behavioural dot-product unit
module tb_dp_row_scheduler;
    localparam int ELEM_W = 32;
    localparam int MULT_W = 3;
    localparam int ADDR_W = 10;
    localparam int ROW_W  = 8;
    localparam int GAP    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ROW_W-1:0]  cmd_rows = '0;
    logic [MULT_W-1:0] cmd_pkgs = '0;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              dp_row_start;
    logic [MULT_W-1:0] dp_no_of_multiples;
    logic              dp_read_now;
    logic              dp_prepare = 1'b0;
    logic              dp_finish = 1'b0;
    logic [ELEM_W-1:0] dp_result = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [ELEM_W-1:0] res_data;
    logic [ROW_W-1:0]  res_row;
    logic              busy;
    logic              done;
`ifdef DP_SCHED_PERF_EN
    logic [15:0]       perf_stall;
`endif

    always #5 clk = ~clk;

    dp_row_scheduler dut (
        .clk               (clk),
        .reset             (reset),
`ifdef DP_SCHED_PERF_EN
        .perf_stall        (perf_stall),
`endif
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_rows          (cmd_rows),
        .cmd_pkgs          (cmd_pkgs),
        .cmd_base          (cmd_base),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_addr       (mem_rd_addr),
        .dp_row_start      (dp_row_start),
        .dp_no_of_multiples(dp_no_of_multiples),
        .dp_read_now       (dp_read_now),
        .dp_prepare        (dp_prepare),
        .dp_finish         (dp_finish),
        .dp_result         (dp_result),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .res_row           (res_row),
        .busy              (busy),
        .done              (done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [ADDR_W-1:0]       exp_addr_q[$];
    logic [ROW_W+ELEM_W-1:0] exp_res_q[$];
    int   exp_pkgs = 0;
    int   job_id = 0;
    int   prep_delay = 3;
    int   n_row_start = 0;
    int   n_read_now = 0;
    int   n_rd_en = 0;
    int   last_rd = -1;
    logic rd_d = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Dot-product unit: counts packages, raises finish 2 cycles and prepare
    // prep_delay cycles after the last dp_read_now; row_start re-arms it.
    int m_cnt = 0, m_since = -1, m_row = 0, m_cur = 0;
    always @(negedge clk) begin
        if (reset) begin
            m_cnt = 0; m_since = -1; m_row = 0;
            dp_finish = 1'b0; dp_prepare = 1'b0;
        end else begin
            if (dp_row_start) begin
                m_cnt = 0; m_since = -1; m_cur = m_row; m_row++;
                dp_finish = 1'b0; dp_prepare = 1'b0;
            end
            if (dp_read_now) begin
                m_cnt++;
                if (m_cnt == int'(dp_no_of_multiples)) m_since = 0;
            end else if (m_since >= 0) begin
                m_since++;
                if (m_since == 2) begin
                    dp_finish = 1'b1;
                    dp_result = {16'hD0D0, 8'(job_id), 8'(m_cur)};
                end
                if (m_since == prep_delay) dp_prepare = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a read or a result.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            rd_d = 1'b0;
        end else begin
            if (dp_row_start) begin
                n_row_start++;
                last_rd = -1;
                chk("row_start_mult", 64'(dp_no_of_multiples), 64'(exp_pkgs));
            end
            if (mem_rd_en) begin
                n_rd_en++;
                if (exp_addr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_unexpected: addr 0x%0h with no read expected", mem_rd_addr);
                end else begin
                    chk("rd_addr", 64'(mem_rd_addr), 64'(exp_addr_q.pop_front()));
                end
                if (last_rd >= 0) chk("rd_gap", 64'(cyc - last_rd), 64'(GAP));
                last_rd = cyc;
            end
            if (rd_d || dp_read_now) chk("read_now_lag", 64'(dp_read_now), 64'(rd_d));
            if (dp_read_now) begin
                n_read_now++;
                chk("read_now_mult", 64'(dp_no_of_multiples), 64'(exp_pkgs));
            end
            if (res_valid && res_ready) begin
                if (exp_res_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL res_unexpected: row %0d data 0x%0h with no result expected", res_row, res_data);
                end else begin
                    chk("result", 64'({res_row, res_data}), 64'(exp_res_q.pop_front()));
                end
            end
            rd_d = mem_rd_en;
        end
    end

    task automatic start_job(input int rows, input int pkgs, input int base, input int pd);
        @(negedge clk);
        job_id++;
        exp_pkgs = pkgs; prep_delay = pd;
        n_row_start = 0; n_read_now = 0; n_rd_en = 0; m_row = 0;
        if (pkgs > 0) begin
            for (int r = 0; r < rows; r++) begin
                for (int k = 0; k < pkgs; k++)
                    exp_addr_q.push_back(ADDR_W'((base + r * pkgs + k) % 1024));
                exp_res_q.push_back({8'(r), 16'hD0D0, 8'(job_id), 8'(r)});
            end
        end
        cmd_rows = ROW_W'(rows); cmd_pkgs = MULT_W'(pkgs); cmd_base = ADDR_W'(base);
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_job(input string name, input int rows, input int reads, output int lat);
        lat = 0;
        while (!done && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_row_starts"}, 64'(n_row_start), 64'(rows));
        chk({name, "_rd_en"}, 64'(n_rd_en), 64'(reads));
        chk({name, "_read_now"}, 64'(n_read_now), 64'(reads));
        chk({name, "_addr_left"}, 64'(exp_addr_q.size()), 64'd0);
        chk({name, "_res_left"}, 64'(exp_res_q.size()), 64'd0);
        @(negedge clk);
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
        chk({name, "_idle_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int t;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_row_start", 64'(dp_row_start), 64'd0);
        chk("rst_mult", 64'(dp_no_of_multiples), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        start_job(1, 3, 'h010, 6);
        finish_job("single_row", 1, 3, lat);

        start_job(3, 2, 'h3FE, 3);
        finish_job("wrap", 3, 6, lat);

        res_ready = 1'b0;
        start_job(6, 1, 'h080, 3);
        repeat (60) @(negedge clk);
        chk("held_row_starts", 64'(n_row_start), 64'd4);
        chk("held_busy", 64'(busy), 64'd1);
        chk("held_res_valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        finish_job("backpressure", 6, 6, lat);

        start_job(0, 2, 'h050, 3);
        finish_job("zero_rows", 0, 0, lat);
        chk("zero_rows_latency", 64'(lat), 64'd0);
        start_job(2, 0, 'h050, 3);
        finish_job("zero_pkgs", 0, 0, lat);
        chk("zero_pkgs_latency", 64'(lat), 64'd0);

        start_job(1, 1, 'h060, 3);
        cmd_valid = 1'b1;
        chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("busy_flag", 64'(busy), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        finish_job("busy_job", 1, 1, lat);

        start_job(3, 3, 'h100, 3);
        t = 0;
        while (!(n_row_start == 2 && n_rd_en >= 4) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("midrow_row_starts", 64'(n_row_start), 64'd2);
        chk("midrow_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        exp_addr_q.delete();
        exp_res_q.delete();
        @(negedge clk);
        chk("midrow_rst_ready", 64'(cmd_ready), 64'd1);
        chk("midrow_rst_valid", 64'(res_valid), 64'd0);
        chk("midrow_rst_busy", 64'(busy), 64'd0);
        chk("midrow_rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("midrow_rst_read_now", 64'(dp_read_now), 64'd0);
        reset = 1'b0;
        start_job(2, 2, 'h200, 3);
        finish_job("after_reset", 2, 4, lat);

        start_job(2, 1, 'h300, 10);
        finish_job("long_prep", 2, 2, lat);
`ifdef DP_SCHED_PERF_EN
        chk("perf_stall", 64'(perf_stall), 64'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dp_row_scheduler.md
DP_ROW_SCHEDULER -- requirements
Module: dp_row_scheduler

Interface
REQ-001 SHALL have parameter ELEM_W, 32, dot-product element/result width.
REQ-002 SHALL have parameter MULT_W, 3, packages-per-row field width.
REQ-003 SHALL have parameter ADDR_W, 10, operand memory package address width.
REQ-004 SHALL have parameter ROW_W, 8, row count/index width.
REQ-005 SHALL have parameter PKG_GAP, 2, minimum cycles between dp_read_now pulses (half-width multiplier bank).
REQ-006 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-009 SHALL have port cmd_rows  in  ROW_W  rows in job; cmd_pkgs  in  MULT_W  packages per row; cmd_base  in  ADDR_W  first package address.
REQ-010 SHALL have port mem_rd_en/mem_rd_addr  out  1/ADDR_W  operand memory read, fixed 1-cycle read latency.
REQ-011 SHALL have port dp_row_start  out  1  one-cycle row-start pulse to the dot-product unit reset input.
REQ-012 SHALL have port dp_no_of_multiples  out  MULT_W  packages in current row.
REQ-013 SHALL have port dp_read_now  out  1  package-valid pulse to dot-product unit.
REQ-014 SHALL have ports dp_prepare  in  1  unit ready for next row; dp_finish  in  1  level finish flag; dp_result  in  ELEM_W  row result.
REQ-015 SHALL have ports res_valid/res_ready  out/in  1/1, res_data  out  ELEM_W, res_row  out  ROW_W  result stream.
REQ-016 SHALL have ports busy  out  1  job active; done  out  1  one-cycle pulse after last result accepted.

Function
REQ-017 SHALL assert cmd_ready only in state IDLE; cmd_valid&&cmd_ready latches rows, pkgs, base and enters ROW_START.
REQ-018 SHALL implement states IDLE, ROW_START, ISSUE, WAIT_PREP, DRAIN.
REQ-019 ROW_START SHALL pulse dp_row_start one cycle with dp_no_of_multiples=pkgs, then enter ISSUE; dp_no_of_multiples SHALL hold stable for the whole row.
REQ-020 ISSUE SHALL assert mem_rd_en once per package, PKG_GAP cycles apart, mem_rd_addr=(base+row*pkgs+k) mod 2^ADDR_W; dp_read_now SHALL follow each mem_rd_en by exactly 1 cycle.
REQ-021 After the last package of a row the FSM SHALL enter WAIT_PREP and go to ROW_START of the next row on the first cycle dp_prepare=1.
REQ-022 ROW_START SHALL be held (no pulse) while outstanding rows plus buffered results equal 4 (result buffer full).
REQ-023 A rising edge of dp_finish SHALL push {row index, dp_result} into a 4-deep result FIFO; rows complete in issue order.
REQ-024 res_valid SHALL equal FIFO non-empty; pop on res_valid&&res_ready; push and pop in the same cycle SHALL both take effect.
REQ-025 After the last row issues, state SHALL be DRAIN until all results popped, then pulse done and return to IDLE.
REQ-026 cmd_rows=0 or cmd_pkgs=0 SHALL be accepted, issue nothing, and pulse done on the next cycle.
REQ-027 busy SHALL be 1 in every state except IDLE.

Reset
REQ-028 reset SHALL force IDLE, FIFO empty, counters 0, and all outputs 0 except cmd_ready=1, including mid-row; the dot-product unit is re-armed by the next dp_row_start.

Configuration
REQ-029 With DP_SCHED_PERF_EN defined, output perf_stall  out  16  SHALL count cycles in WAIT_PREP plus full-buffer holds, saturating at 16'hFFFF, cleared by reset and at command acceptance; without it the port and counter SHALL be absent.

Structure
REQ-030 State enum, PKG_GAP and FIFO depth constant SHALL live in shared package dp_sched_pkg.
REQ-031 Result buffer SHALL be sub-module dp_result_fifo (4 entries x (ROW_W+ELEM_W)).

Verification
REQ-032 rows=1, pkgs=3, base=0x010, prepare after 6 cycles -> addrs 0x010,0x011,0x012 two cycles apart, three dp_read_now pulses, one result row 0, done.
REQ-033 rows=3, pkgs=2, base=0x3FE -> addresses 0x3FE,0x3FF,0x000,0x001,0x002,0x003 (wrap), results rows 0,1,2 in order.
REQ-034 rows=6, res_ready=0 -> exactly 4 rows issued then ROW_START held; raising res_ready releases rows 4,5.
REQ-035 rows=0 -> no mem_rd_en, done one cycle after acceptance; cmd_valid during busy -> cmd_ready=0.
REQ-036 reset asserted in ISSUE of row 1 -> next cycle IDLE, cmd_ready=1, res_valid=0; new job runs cleanly.
REQ-037 DP_SCHED_PERF_EN: 10 cycles dp_prepare low -> perf_stall=10.
